tty_write_arbiter: RTL

TTY_WRITE_ARBITER -- requirements
Module: tty_write_arbiter

---
 rtl/tty_write_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/tty_write_arbiter.sv
// Small show-ahead FIFO: rd_dat is the head entry; a push while full is accepted only if a pop frees a slot.
// Latency: a push is visible at rd_dat the cycle after; no backpressure, callers check full/empty.
module tty_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk_50mhz) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// Merges CPU, UART-RX and keyboard bytes into one VGA write stream (round-robin) and echoes RX/KB bytes to the UART TX.
// Latency: request rise sampled at E0, vm_write during E1..E2; echo waits for tx_busy low, overflows are sticky in ovf.
module tty_write_arbiter #(
  parameter bit ECHO_RX = 1'b1,
  parameter bit ECHO_KB = 1'b1
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       cpu_write,
  input  logic [7:0] cpu_data,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       kb_released,
  input  logic [7:0] kb_ascii,
  input  logic       key_ack,
  input  logic       tx_busy,
  output logic       vm_write,
  output logic [7:0] vm_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       key_valid,
  output logic [7:0] key_data,
  output logic [3:0] ovf
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} tx_state_t;

  logic [2:0] req;
  logic [2:0] req_prev;
  logic [2:0] cap;
  logic [2:0] pend;
  logic [2:0] src_ovf;
  logic [2:0] grant;
  logic [1:0] grant_idx;
  logic [1:0] rr_next;
  logic [2:0] cand;
  logic [7:0] src_dat  [3];
  logic [7:0] pend_dat [3];
  logic [7:0] gnt_dat;
  logic       fifo_ovf;
  logic       echo_push;
  logic       tx_pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_head;
  tx_state_t  tx_state;
  logic [1:0] quiet_cnt;

  assign req        = {kb_released, rx_ready, cpu_write};
  assign cap        = req & ~req_prev;
  assign src_dat[0] = cpu_data;
  assign src_dat[1] = rx_data;
  assign src_dat[2] = kb_ascii;
  assign gnt_dat    = pend_dat[grant_idx];
  assign ovf        = {fifo_ovf, src_ovf};

  // Walk candidates from lowest to highest priority so the first pending one after rr_next wins.
  always_comb begin
    grant     = 3'b000;
    grant_idx = 2'd0;
    cand      = 3'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, rr_next} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (pend[cand[1:0]]) begin
        grant     = 3'b001 << cand[1:0];
        grant_idx = cand[1:0];
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_src
    always_ff @(posedge clk_50mhz) begin
      if (rst) begin
        pend[i]     <= 1'b0;
        pend_dat[i] <= 8'h00;
        src_ovf[i]  <= 1'b0;
      end else if (cap[i]) begin
        pend[i]     <= 1'b1;
        pend_dat[i] <= src_dat[i];
        if (pend[i] && !grant[i]) src_ovf[i] <= 1'b1;
      end else if (grant[i]) begin
        pend[i] <= 1'b0;
      end
    end
  end

  assign echo_push = (grant[1] && ECHO_RX) || (grant[2] && ECHO_KB);
  assign tx_pop    = (tx_state == IDLE) && !fifo_empty && !tx_busy;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      req_prev  <= 3'b111;
      rr_next   <= 2'd0;
      vm_write  <= 1'b0;
      vm_data   <= 8'h00;
      key_valid <= 1'b0;
      key_data  <= 8'h00;
      fifo_ovf  <= 1'b0;
    end else begin
      req_prev <= req;
      vm_write <= |grant;
      if (|grant) begin
        vm_data <= gnt_dat;
        rr_next <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end
      if (echo_push && fifo_full && !tx_pop) fifo_ovf <= 1'b1;
      if (cap[2]) begin
        key_valid <= 1'b1;
        key_data  <= kb_ascii;
      end else if (key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

  tty_fifo #(.WIDTH(8), .DEPTH(4)) u_echo_fifo (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .push      (echo_push),
    .wr_dat    (gnt_dat),
    .pop       (tx_pop),
    .rd_dat    (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // WAIT_HI gives up after four quiet cycles so a transmitter that never raises busy cannot stall the echo path.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      tx_state  <= IDLE;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      quiet_cnt <= 2'd0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        IDLE: begin
          if (tx_pop) begin
            tx_data  <= fifo_head;
            tx_start <= 1'b1;
            tx_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          quiet_cnt <= 2'd0;
          tx_state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy)                 tx_state  <= WAIT_LO;
          else if (quiet_cnt == 2'd3)  tx_state  <= IDLE;
          else                         quiet_cnt <= quiet_cnt + 2'd1;
        end
        WAIT_LO: begin
          if (!tx_busy) tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end
endmodule
